bnn_frame_ctrl: RTL and testbench

Frame sequencer between the SPI byte receiver and the BNN inference core. It arms the receiver and accepts each received byte through the valid/taken handshake. It writes exactly IMG_BYTE_COUNT bytes into the image buffer, launches one inference, and presents the classification result until software acknowledges it, then re-arms for the next frame. It also owns frame-level error handling: inter-byte timeout, inference timeout, overrun and abort.

---
 rtl/bnn_frame_ctrl_if.sv | 58 +++++
 rtl/bnn_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_bnn_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_frame_ctrl_if.sv
// bnn_frame_ctrl_if
//
// Bundles every handshake and bus signal of the BNN frame sequencer.
//
// Port summary:
//   master modport - the frame controller side. It samples the SPI byte
//                    stream, inference completion, result acknowledge and
//                    abort. It drives the receiver arm and acknowledge, the
//                    image buffer write port, the inference launch, the
//                    result and the status flags.
//   slave modport  - the surrounding system: SPI receiver, image buffer,
//                    inference core and software, viewed from the far side.
interface bnn_frame_ctrl_if #(
    parameter int IMG_BYTE_COUNT = 113
) ();
    localparam int ADDR_W = $clog2(IMG_BYTE_COUNT);

    // SPI receiver side
    logic [7:0]        spi_rx_data;
    logic              spi_byte_valid;
    logic              byte_taken;
    logic              rx_enable;

    // Image buffer write port
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;

    // Inference core
    logic              infer_start;
    logic              infer_done;
    logic [3:0]        infer_result;

    // Result hand-off and control/status
    logic              result_valid;
    logic [3:0]        result;
    logic              result_ack;
    logic              abort;
    logic [ADDR_W-1:0] byte_count;
    logic              frame_error;
    logic              overrun;

    modport master (
        input  spi_rx_data, spi_byte_valid, infer_done, infer_result,
               result_ack, abort,
        output byte_taken, rx_enable, buf_we, buf_addr, buf_wdata,
               infer_start, result_valid, result, byte_count,
               frame_error, overrun
    );

    modport slave (
        output spi_rx_data, spi_byte_valid, infer_done, infer_result,
               result_ack, abort,
        input  byte_taken, rx_enable, buf_we, buf_addr, buf_wdata,
               infer_start, result_valid, result, byte_count,
               frame_error, overrun
    );
endinterface

// File: rtl/bnn_frame_ctrl.sv
// bnn_frame_ctrl
//
// Frame sequencer between the SPI byte receiver and the BNN inference core.
// It arms the receiver and writes IMG_BYTE_COUNT bytes into the image buffer.
// It then launches one inference and holds the class index until software
// acknowledges it. After the acknowledge it re-arms for the next frame.
// It also handles the frame-level errors: inter-byte timeout, inference
// timeout, overrun and abort.
//
// Ports:
//   clk   - system clock; all logic on posedge
//   rst_n - asynchronous active-low reset
//   bus   - bnn_frame_ctrl_if.master carrying the SPI handshake, the buffer
//           write port, the inference handshake, the result and the status
//           flags
module bnn_frame_ctrl #(
    parameter int IMG_BYTE_COUNT = 113,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    bnn_frame_ctrl_if.master bus
);
    localparam int ADDR_W = $clog2(IMG_BYTE_COUNT);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_BYTE_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECEIVE,
        START,
        INFER,
        REPORT
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             accept;
    logic             timeout;

    // The receiver only drops a byte after it is taken. So the acknowledge
    // must be combinational in the same cycle as spi_byte_valid.
    assign accept          = (state == RECEIVE) && bus.spi_byte_valid && !bus.abort;
    assign bus.byte_taken  = accept;
    assign timeout         = (timer == TMR_W'(TIMEOUT_CYCLES));

    // This block holds the whole sequencer. Every visible output except
    // byte_taken is registered here, alongside the state transition that
    // implies it. buf_we and infer_start are single-cycle strobes, so they
    // default low each cycle. abort takes priority over all other activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            timer            <= '0;
            bus.rx_enable    <= 1'b0;
            bus.buf_we       <= 1'b0;
            bus.buf_addr     <= '0;
            bus.buf_wdata    <= '0;
            bus.infer_start  <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result       <= '0;
            bus.byte_count   <= '0;
            bus.frame_error  <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.buf_we      <= 1'b0;
            bus.infer_start <= 1'b0;

            if (bus.abort) begin
                state            <= IDLE;
                timer            <= '0;
                bus.rx_enable    <= 1'b0;
                bus.result_valid <= 1'b0;
                bus.byte_count   <= '0;
                bus.frame_error  <= 1'b0;
                bus.overrun      <= 1'b0;
            end else begin
                if (bus.spi_byte_valid && (state != RECEIVE)) begin
                    bus.overrun <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        state          <= RECEIVE;
                        timer          <= '0;
                        bus.rx_enable  <= 1'b1;
                        bus.byte_count <= '0;
                    end

                    RECEIVE: begin
                        if (accept) begin
                            timer         <= '0;
                            bus.buf_we    <= 1'b1;
                            bus.buf_addr  <= bus.byte_count;
                            bus.buf_wdata <= bus.spi_rx_data;
                            // The first byte of a new frame is what clears
                            // the errors left over from the previous frame.
                            if (bus.byte_count == '0) begin
                                bus.frame_error <= 1'b0;
                                bus.overrun     <= 1'b0;
                            end
                            if (bus.byte_count == LAST_IDX) begin
                                state           <= START;
                                bus.byte_count  <= '0;
                                bus.rx_enable   <= 1'b0;
                                bus.infer_start <= 1'b1;
                            end else begin
                                bus.byte_count <= bus.byte_count + ADDR_W'(1);
                            end
                        end else if (bus.byte_count == '0) begin
                            // The receiver may idle indefinitely between frames.
                            timer <= '0;
                        end else if (timeout) begin
                            // Drop the partial frame and wait for a fresh one.
                            timer           <= '0;
                            bus.byte_count  <= '0;
                            bus.frame_error <= 1'b1;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end

                    START: begin
                        state <= INFER;
                        timer <= '0;
                    end

                    INFER: begin
                        if (bus.infer_done) begin
                            state            <= REPORT;
                            timer            <= '0;
                            bus.result       <= bus.infer_result;
                            bus.result_valid <= 1'b1;
                        end else if (timeout) begin
                            state           <= IDLE;
                            timer           <= '0;
                            bus.frame_error <= 1'b1;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end

                    REPORT: begin
                        if (bus.result_ack) begin
                            state            <= IDLE;
                            bus.result_valid <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bnn_frame_ctrl.sv
// tb_bnn_frame_ctrl
//
// Self-checking bench for bnn_frame_ctrl. It drives directed frame scenarios
// with random byte values, random inter-byte gaps and random class indices.
// Frame-level expectations come from a simple reference model: the bytes
// sent, the writes captured into a shadow buffer, and the frame rules.
// The timeout is shortened so the timeout scenarios stay brief.
module tb_bnn_frame_ctrl;
    localparam int IMG = 113;
    localparam int TO  = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    bnn_frame_ctrl_if #(.IMG_BYTE_COUNT(IMG)) bus ();

    bnn_frame_ctrl #(
        .IMG_BYTE_COUNT(IMG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Shadow image buffer plus running totals of writes and launches.
    logic [7:0] mem  [IMG];
    logic [7:0] sent [IMG];
    int wr_count    = 0;
    int start_count = 0;
    int bad_addr    = 0;

    always @(negedge clk) begin
        if (bus.buf_we) begin
            if (int'(bus.buf_addr) < IMG) mem[int'(bus.buf_addr)] = bus.buf_wdata;
            else bad_addr++;
            wr_count++;
        end
        if (bus.infer_start) start_count++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    int wr_base;
    int start_base;

    // Advance to just after the next falling edge, where registered outputs are stable.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one byte for one cycle. Back-to-back calls give back-to-back bytes.
    task automatic apply_stimulus(input logic [7:0] b);
        bus.spi_rx_data    = b;
        bus.spi_byte_valid = 1'b1;
        #1 check_output("byte_taken", 32'(bus.byte_taken), 32'd1);
        step();
        bus.spi_byte_valid = 1'b0;
    endtask

    // Send n bytes, either counting 0,1,2... or random. It ends in the cycle
    // after the last accept and adds no gap after the final byte.
    task automatic send_frame(input int n, input bit counting);
        logic [7:0] b;
        wr_base    = wr_count;
        start_base = start_count;
        for (int i = 0; i < n; i++) begin
            b = counting ? 8'(i) : 8'($urandom);
            sent[i] = b;
            apply_stimulus(b);
            if (i == 0) begin
                check_output("first_byte_clears_frame_error", 32'(bus.frame_error), 32'd0);
                check_output("first_byte_clears_overrun", 32'(bus.overrun), 32'd0);
            end
            if (i != n - 1) step($urandom_range(0, 2));
        end
    endtask

    // A completed frame: all bytes written in order and one launch, at the same time as the last write.
    task automatic verify_full_frame();
        int errs;
        errs = 0;
        check_output("last_buf_we", 32'(bus.buf_we), 32'd1);
        check_output("last_buf_addr", 32'(bus.buf_addr), 32'(IMG - 1));
        check_output("infer_start_with_last", 32'(bus.infer_start), 32'd1);
        check_output("rx_enable_off_after_last", 32'(bus.rx_enable), 32'd0);
        for (int i = 0; i < IMG; i++) if (mem[i] !== sent[i]) errs++;
        check_output("write_count", 32'(wr_count - wr_base), 32'(IMG));
        check_output("buffer_contents_errors", 32'(errs), 32'd0);
        check_output("bad_addr", 32'(bad_addr), 32'd0);
        step();
        check_output("infer_start_once", 32'(start_count - start_base), 32'd1);
        check_output("infer_start_single_cycle", 32'(bus.infer_start), 32'd0);
    endtask

    // Deliver infer_done while in INFER, then hold the result and acknowledge it.
    task automatic complete_inference(input logic [3:0] r);
        bus.infer_result = r;
        bus.infer_done   = 1'b1;
        step();
        bus.infer_done   = 1'b0;
        bus.infer_result = 4'($urandom);
        check_output("result_valid_set", 32'(bus.result_valid), 32'd1);
        check_output("result_value", 32'(bus.result), 32'(r));
        step($urandom_range(1, 5));
        check_output("result_valid_held", 32'(bus.result_valid), 32'd1);
        check_output("result_held", 32'(bus.result), 32'(r));
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        check_output("result_valid_cleared", 32'(bus.result_valid), 32'd0);
        check_output("rx_enable_idle", 32'(bus.rx_enable), 32'd0);
        step();
        check_output("rx_enable_rearmed", 32'(bus.rx_enable), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_rx_enable"}, 32'(bus.rx_enable), 32'd0);
        check_output({tag, "_byte_taken"}, 32'(bus.byte_taken), 32'd0);
        check_output({tag, "_buf_we"}, 32'(bus.buf_we), 32'd0);
        check_output({tag, "_buf_addr"}, 32'(bus.buf_addr), 32'd0);
        check_output({tag, "_buf_wdata"}, 32'(bus.buf_wdata), 32'd0);
        check_output({tag, "_infer_start"}, 32'(bus.infer_start), 32'd0);
        check_output({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        check_output({tag, "_result"}, 32'(bus.result), 32'd0);
        check_output({tag, "_byte_count"}, 32'(bus.byte_count), 32'd0);
        check_output({tag, "_frame_error"}, 32'(bus.frame_error), 32'd0);
        check_output({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    endtask

    logic [3:0] r;

    initial begin
        bus.spi_rx_data    = '0;
        bus.spi_byte_valid = 1'b0;
        bus.infer_done     = 1'b0;
        bus.infer_result   = '0;
        bus.result_ack     = 1'b0;
        bus.abort          = 1'b0;

        // Reset values and arming after release.
        #2;
        check_reset_values("reset");
        step(2);
        rst_n = 1'b1;
        check_output("rx_enable_before_edge", 32'(bus.rx_enable), 32'd0);
        step(2);
        check_output("rx_enable_after_release", 32'(bus.rx_enable), 32'd1);

        // Full counting frame with class 7.
        $display("[TB] full counting frame");
        send_frame(IMG, 1'b1);
        verify_full_frame();
        complete_inference(4'd7);

        // Partial frame followed by silence.
        $display("[TB] partial frame timeout");
        send_frame(50, 1'b0);
        step();
        check_output("partial_byte_count", 32'(bus.byte_count), 32'd50);
        check_output("partial_write_count", 32'(wr_count - wr_base), 32'd50);
        step(TO - 21);
        check_output("no_early_timeout", 32'(bus.frame_error), 32'd0);
        step(40);
        check_output("recv_timeout_flag", 32'(bus.frame_error), 32'd1);
        check_output("recv_timeout_discard", 32'(bus.byte_count), 32'd0);
        check_output("recv_timeout_rx_enable", 32'(bus.rx_enable), 32'd1);
        send_frame(IMG, 1'b0);
        verify_full_frame();
        r = 4'($urandom);
        complete_inference(r);

        // Overrun while inference is running.
        $display("[TB] overrun during inference");
        send_frame(IMG, 1'b0);
        verify_full_frame();
        bus.spi_rx_data    = 8'($urandom);
        bus.spi_byte_valid = 1'b1;
        #1 check_output("overrun_not_taken", 32'(bus.byte_taken), 32'd0);
        step();
        bus.spi_byte_valid = 1'b0;
        check_output("overrun_flag", 32'(bus.overrun), 32'd1);
        check_output("overrun_no_buf_we", 32'(bus.buf_we), 32'd0);
        check_output("overrun_write_count", 32'(wr_count - wr_base), 32'(IMG));
        r = 4'($urandom);
        complete_inference(r);
        check_output("overrun_sticky", 32'(bus.overrun), 32'd1);

        // Abort with a valid byte in the same cycle, after 60 bytes.
        $display("[TB] abort mid-frame");
        send_frame(60, 1'b0);
        step();
        bus.spi_rx_data    = 8'($urandom);
        bus.spi_byte_valid = 1'b1;
        bus.abort          = 1'b1;
        #1 check_output("abort_byte_not_taken", 32'(bus.byte_taken), 32'd0);
        step();
        bus.spi_byte_valid = 1'b0;
        bus.abort          = 1'b0;
        check_output("abort_no_buf_we", 32'(bus.buf_we), 32'd0);
        check_output("abort_byte_count", 32'(bus.byte_count), 32'd0);
        check_output("abort_idle_rx_enable", 32'(bus.rx_enable), 32'd0);
        check_output("abort_clears_overrun", 32'(bus.overrun), 32'd0);
        check_output("abort_write_count", 32'(wr_count - wr_base), 32'd60);
        step();
        check_output("abort_rearm", 32'(bus.rx_enable), 32'd1);

        // Inference that never finishes.
        $display("[TB] inference hang");
        send_frame(IMG, 1'b0);
        verify_full_frame();
        step(TO + 10);
        check_output("infer_timeout_flag", 32'(bus.frame_error), 32'd1);
        check_output("infer_timeout_no_result", 32'(bus.result_valid), 32'd0);
        check_output("infer_timeout_rearm", 32'(bus.rx_enable), 32'd1);

        // Asynchronous reset while a result is being presented.
        $display("[TB] async reset in REPORT");
        send_frame(IMG, 1'b0);
        verify_full_frame();
        bus.infer_result = 4'($urandom_range(1, 15));
        bus.infer_done   = 1'b1;
        step();
        bus.infer_done   = 1'b0;
        check_output("report_before_reset", 32'(bus.result_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        step(2);
        rst_n = 1'b1;
        step(2);
        check_output("rx_enable_after_second_release", 32'(bus.rx_enable), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
